// File: rtl/led_matrix_pkg.sv
// Shared types and board defaults for the LED dot-matrix scanner.
package led_matrix_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 16;

  // Map a logical "line is on" flag to the physical pin level.
  function automatic logic polarity(input logic active, input logic act_low);
    return active ^ act_low;
  endfunction

endpackage

// File: rtl/led_matrix_scanner_frame_buffer_2x.sv
// Double-buffered frame store: writes land in the back bank, reads come
// from the front bank, and a toggle swaps the roles of the two banks.
module frame_buffer_2x #(
  parameter int ROWS = 8,
  parameter int COLS = 16,
  parameter int RW   = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            toggle,
  input  logic [RW-1:0]   rd_row,
  output logic [COLS-1:0] rd_data
);

  localparam logic [RW:0] ROWS_LIM = (RW+1)'(ROWS);

  logic [COLS-1:0] bank0 [ROWS];
  logic [COLS-1:0] bank1 [ROWS];
  logic            front_sel;
  logic            wr_ok;

  // Out-of-range row indices are dropped rather than aliased.
  assign wr_ok = wr_en && ({1'b0, wr_row} < ROWS_LIM);

  // Back-bank write; the write sees the select value from before any
  // same-edge toggle, so data written alongside a swap becomes the new front.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (wr_ok) begin
      if (front_sel) bank0[wr_row] <= wr_data;
      else           bank1[wr_row] <= wr_data;
    end
  end

  // Front-select flip-flop: 0 = bank0 is displayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      front_sel <= 1'b0;
    else if (toggle) front_sel <= ~front_sel;
  end

  assign rd_data = front_sel ? bank1[rd_row] : bank0[rd_row];

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-scan driver for the LED dot matrix: alternates BLANK and DRIVE per row,
// applies requested buffer swaps only at frame ends, and registers all pins.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int ROWS        = MATRIX_ROWS,
  parameter int COLS        = MATRIX_COLS,
  parameter int DWELL       = 1024,
  parameter int BLANK       = 16,
  parameter bit ROW_ACT_LOW = 1'b1,
  parameter bit COL_ACT_LOW = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     scan_en,
  input  logic                     wr_en,
  input  logic [$clog2(ROWS)-1:0]  wr_row,
  input  logic [COLS-1:0]          wr_data,
  input  logic                     swap_req,
  output logic                     swap_pend,
  output logic                     frame_start,
  output logic [ROWS-1:0]          row_out,
  output logic [COLS-1:0]          col_out
);

  localparam int RW      = $clog2(ROWS);
  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  scan_state_t     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic            paused_q, paused_d;
  logic            swap_pend_d;
  logic            frame_end;
  logic            toggle;
  logic [COLS-1:0] front_row;
  logic [ROWS-1:0] row_out_d;
  logic [COLS-1:0] col_out_d;
  logic            frame_start_d;

  frame_buffer_2x #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (RW)
  ) u_fb (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .toggle  (toggle),
    .rd_row  (row_q),
    .rd_data (front_row)
  );

  // A same-cycle request counts for this frame end, so pend never sets then.
  assign toggle = frame_end && (swap_pend || swap_req);

  // Scan state, dwell counter, row index, pause flag and swap request.
  // The counter is 0 out of reset, so the very first BLANK is one cycle long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BLANK;
      cnt_q     <= '0;
      row_q     <= '0;
      paused_q  <= 1'b0;
      swap_pend <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      paused_q  <= paused_d;
      swap_pend <= swap_pend_d;
    end
  end

  // Next-state: down-counter per state; a pause freezes position and the
  // resume always restarts with a full BLANK on the current row.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    paused_d    = paused_q;
    frame_end   = 1'b0;
    if (!scan_en) begin
      paused_d = 1'b1;
    end else if (paused_q) begin
      paused_d = 1'b0;
      state_d  = ST_BLANK;
      cnt_d    = BLANK_LD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (state_q == ST_BLANK) begin
      state_d = ST_DRIVE;
      cnt_d   = DWELL_LD;
    end else begin
      state_d   = ST_BLANK;
      cnt_d     = BLANK_LD;
      frame_end = (row_q == LAST_ROW);
      row_d     = frame_end ? '0 : row_q + 1'b1;
    end
    swap_pend_d = toggle ? 1'b0 : (swap_pend | swap_req);
  end

  // Output values for the next edge: inactive unless driving, row pattern
  // and columns captured on DRIVE entry, then held for the dwell.
  always_comb begin
    row_out_d     = row_out;
    col_out_d     = col_out;
    frame_start_d = 1'b0;
    if (!(scan_en && state_d == ST_DRIVE)) begin
      for (int i = 0; i < ROWS; i++) row_out_d[i] = polarity(1'b0, ROW_ACT_LOW);
      for (int i = 0; i < COLS; i++) col_out_d[i] = polarity(1'b0, COL_ACT_LOW);
    end else if (state_q != ST_DRIVE) begin
      for (int i = 0; i < ROWS; i++) row_out_d[i] = polarity(row_q == RW'(i), ROW_ACT_LOW);
      for (int i = 0; i < COLS; i++) col_out_d[i] = polarity(front_row[i], COL_ACT_LOW);
      frame_start_d = (row_q == '0);
    end
  end

  // Registered pins; reset forces them inactive immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_out     <= {ROWS{polarity(1'b0, ROW_ACT_LOW)}};
      col_out     <= {COLS{polarity(1'b0, COL_ACT_LOW)}};
      frame_start <= 1'b0;
    end else begin
      row_out     <= row_out_d;
      col_out     <= col_out_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: three instances cover the board
// configuration, an active-high 4x5 matrix and a 3-row matrix.
module tb_led_matrix_scanner;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  // u0: 8x16, active-low, DWELL=4, BLANK=2 (frame 48)
  logic        scan_en0, wr_en0, swap_req0, swap_pend0, fs0;
  logic [2:0]  wr_row0;
  logic [15:0] wr_data0, col_out0;
  logic [7:0]  row_out0;
  // u1: 4x5, active-high, DWELL=4, BLANK=2 (frame 24)
  logic        scan_en1, wr_en1, swap_req1, swap_pend1, fs1;
  logic [1:0]  wr_row1;
  logic [4:0]  wr_data1, col_out1;
  logic [3:0]  row_out1;
  // u2: 3x4, active-high, DWELL=2, BLANK=1 (frame 9)
  logic        scan_en2, wr_en2, swap_req2, swap_pend2, fs2;
  logic [1:0]  wr_row2;
  logic [3:0]  wr_data2, col_out2;
  logic [2:0]  row_out2;

  led_matrix_scanner #(.ROWS(8), .COLS(16), .DWELL(4), .BLANK(2),
                       .ROW_ACT_LOW(1'b1), .COL_ACT_LOW(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en0), .wr_en(wr_en0), .wr_row(wr_row0),
    .wr_data(wr_data0), .swap_req(swap_req0), .swap_pend(swap_pend0),
    .frame_start(fs0), .row_out(row_out0), .col_out(col_out0));

  led_matrix_scanner #(.ROWS(4), .COLS(5), .DWELL(4), .BLANK(2),
                       .ROW_ACT_LOW(1'b0), .COL_ACT_LOW(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en1), .wr_en(wr_en1), .wr_row(wr_row1),
    .wr_data(wr_data1), .swap_req(swap_req1), .swap_pend(swap_pend1),
    .frame_start(fs1), .row_out(row_out1), .col_out(col_out1));

  led_matrix_scanner #(.ROWS(3), .COLS(4), .DWELL(2), .BLANK(1),
                       .ROW_ACT_LOW(1'b0), .COL_ACT_LOW(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en2), .wr_en(wr_en2), .wr_row(wr_row2),
    .wr_data(wr_data2), .swap_req(swap_req2), .swap_pend(swap_pend2),
    .frame_start(fs2), .row_out(row_out2), .col_out(col_out2));

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((which == 0 && fs0) || (which == 1 && fs1) || (which == 2 && fs2)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    tests++; if (row_out0 !== 8'hFF || col_out0 !== 16'hFFFF) begin failed++;
      $display("FAIL reset_lines_u0: row=%h col=%h required ff ffff", row_out0, col_out0); end
    tests++; if ({swap_pend0, fs0} !== 2'b00) begin failed++;
      $display("FAIL reset_flags_u0: pend,fs=%b required 00", {swap_pend0, fs0}); end
    tests++; if (row_out1 !== 4'h0 || col_out1 !== 5'h0) begin failed++;
      $display("FAIL reset_lines_u1: row=%h col=%h required 0 0", row_out1, col_out1); end
    tests++; if (row_out2 !== 3'h0 || col_out2 !== 4'h0) begin failed++;
      $display("FAIL reset_lines_u2: row=%h col=%h required 0 0", row_out2, col_out2); end
    rst_n = 1'b1;
  endtask

  task automatic test_swap_scan();
    bit ok;
    logic [7:0]  er;
    logic [15:0] ec;
    step(2);
    for (int r = 0; r < 8; r++) begin
      wr_en0 = 1'b1; wr_row0 = 3'(r); wr_data0 = 16'h0001 << r; step(1);
    end
    wr_en0 = 1'b0; swap_req0 = 1'b1; step(1); swap_req0 = 1'b0;
    tests++; if (swap_pend0 !== 1'b1) begin failed++;
      $display("FAIL scan_pend_set: pend=%b required 1", swap_pend0); end
    wait_fs(0, ok);
    tests++; if (!ok) begin failed++; $display("FAIL scan_fs_timeout: got none required frame_start"); end
    for (int k = 0; k <= 48; k++) begin
      int r, ph;
      r = (k % 48) / 6; ph = k % 6;
      er = (ph < 4) ? ~(8'h01 << r) : 8'hFF;
      ec = (ph < 4) ? ~(16'h0001 << r) : 16'hFFFF;
      tests++; if ({row_out0, col_out0, fs0} !== {er, ec, (k % 48 == 0)}) begin failed++;
        $display("FAIL scan_k%0d: row=%h col=%h fs=%b required %h %h %b",
                 k, row_out0, col_out0, fs0, er, ec, (k % 48 == 0)); end
      step(1);
    end
  endtask

  task automatic test_swap_midframe();
    bit ok;
    wait_fs(0, ok);
    tests++; if (!ok) begin failed++; $display("FAIL mid_fs_timeout: got none required frame_start"); end
    step(10);
    wr_en0 = 1'b1; wr_row0 = 3'd3; wr_data0 = 16'hA5A5; swap_req0 = 1'b1;
    step(1); wr_en0 = 1'b0; swap_req0 = 1'b0;                        // k=11
    tests++; if (swap_pend0 !== 1'b1) begin failed++;
      $display("FAIL mid_pend_set: pend=%b required 1", swap_pend0); end
    step(8);                                                          // k=19
    tests++; if (row_out0 !== 8'hF7 || col_out0 !== 16'hFFF7) begin failed++;
      $display("FAIL mid_old_row3: row=%h col=%h required f7 fff7", row_out0, col_out0); end
    step(26);                                                         // k=45
    tests++; if (swap_pend0 !== 1'b1) begin failed++;
      $display("FAIL mid_pend_row7: pend=%b required 1", swap_pend0); end
    step(1);                                                          // k=46
    tests++; if (swap_pend0 !== 1'b0) begin failed++;
      $display("FAIL mid_pend_clear: pend=%b required 0", swap_pend0); end
    step(2);                                                          // k=48
    tests++; if ({fs0, row_out0, col_out0} !== {1'b1, 8'hFE, 16'hFFFF}) begin failed++;
      $display("FAIL mid_new_row0: fs=%b row=%h col=%h required 1 fe ffff", fs0, row_out0, col_out0); end
    step(19);                                                         // k=67
    tests++; if (row_out0 !== 8'hF7 || col_out0 !== 16'h5A5A) begin failed++;
      $display("FAIL mid_new_row3: row=%h col=%h required f7 5a5a", row_out0, col_out0); end
  endtask

  task automatic test_double_swap();
    bit ok;
    wait_fs(0, ok);
    tests++; if (!ok) begin failed++; $display("FAIL dbl_fs_timeout: got none required frame_start"); end
    step(5); swap_req0 = 1'b1; step(1); swap_req0 = 1'b0;             // k=6
    step(14); swap_req0 = 1'b1; step(1); swap_req0 = 1'b0;            // k=21
    tests++; if (swap_pend0 !== 1'b1) begin failed++;
      $display("FAIL dbl_pend: pend=%b required 1", swap_pend0); end
    step(27);                                                         // k=48
    tests++; if (fs0 !== 1'b1) begin failed++; $display("FAIL dbl_fs: fs=%b required 1", fs0); end
    step(19);                                                         // k=67
    tests++; if (col_out0 !== 16'hFFF7) begin failed++;
      $display("FAIL dbl_one_toggle: col=%h required fff7", col_out0); end
    step(26); swap_req0 = 1'b1; step(1); swap_req0 = 1'b0;            // k=94
    tests++; if (swap_pend0 !== 1'b0) begin failed++;
      $display("FAIL coin_pend: pend=%b required 0", swap_pend0); end
    step(2);                                                          // k=96
    tests++; if ({fs0, swap_pend0} !== 2'b10) begin failed++;
      $display("FAIL coin_fs: fs,pend=%b required 10", {fs0, swap_pend0}); end
    step(19);                                                         // k=115
    tests++; if (col_out0 !== 16'h5A5A) begin failed++;
      $display("FAIL coin_toggle: col=%h required 5a5a", col_out0); end
  endtask

  task automatic test_pause();
    bit ok;
    step(1);
    wr_en1 = 1'b1; wr_row1 = 2'd2; wr_data1 = 5'b10110; step(1);
    wr_en1 = 1'b0; swap_req1 = 1'b1; step(1); swap_req1 = 1'b0;
    wait_fs(1, ok);
    tests++; if (!ok) begin failed++; $display("FAIL pause_fs_timeout: got none required frame_start"); end
    step(12);                                                         // k=12
    tests++; if (row_out1 !== 4'b0100 || col_out1 !== 5'b10110) begin failed++;
      $display("FAIL pause_pre: row=%b col=%b required 0100 10110", row_out1, col_out1); end
    step(1); scan_en1 = 1'b0;                                         // k=13
    step(1);                                                          // k=14
    tests++; if (row_out1 !== 4'h0 || col_out1 !== 5'h0) begin failed++;
      $display("FAIL pause_first: row=%b col=%b required 0000 00000", row_out1, col_out1); end
    step(9);                                                          // k=23
    tests++; if (row_out1 !== 4'h0 || col_out1 !== 5'h0) begin failed++;
      $display("FAIL pause_last: row=%b col=%b required 0000 00000", row_out1, col_out1); end
    scan_en1 = 1'b1;
    step(2);                                                          // k=25
    tests++; if (row_out1 !== 4'h0 || col_out1 !== 5'h0) begin failed++;
      $display("FAIL resume_blank: row=%b col=%b required 0000 00000", row_out1, col_out1); end
    step(1);                                                          // k=26
    tests++; if ({row_out1, col_out1, fs1} !== {4'b0100, 5'b10110, 1'b0}) begin failed++;
      $display("FAIL resume_drive: row=%b col=%b fs=%b required 0100 10110 0", row_out1, col_out1, fs1); end
    step(3);                                                          // k=29
    tests++; if (row_out1 !== 4'b0100 || col_out1 !== 5'b10110) begin failed++;
      $display("FAIL resume_dwell_end: row=%b col=%b required 0100 10110", row_out1, col_out1); end
    step(1);                                                          // k=30
    tests++; if (row_out1 !== 4'h0 || col_out1 !== 5'h0) begin failed++;
      $display("FAIL resume_after: row=%b col=%b required 0000 00000", row_out1, col_out1); end
  endtask

  task automatic test_out_of_range();
    bit ok;
    step(1);
    for (int r = 0; r < 3; r++) begin
      wr_en2 = 1'b1; wr_row2 = 2'(r); wr_data2 = 4'(1 << r); step(1);
    end
    wr_row2 = 2'd3; wr_data2 = 4'hF; step(1);
    wr_en2 = 1'b0; swap_req2 = 1'b1; step(1); swap_req2 = 1'b0;
    wait_fs(2, ok);                                                   // k=0
    tests++; if (!ok) begin failed++; $display("FAIL oor_fs_timeout: got none required frame_start"); end
    tests++; if (row_out2 !== 3'b001 || col_out2 !== 4'h1) begin failed++;
      $display("FAIL oor_row0: row=%b col=%h required 001 1", row_out2, col_out2); end
    step(1); wr_en2 = 1'b1; wr_row2 = 2'd0; wr_data2 = 4'hF; step(1); wr_en2 = 1'b0;  // k=2
    step(1);                                                          // k=3
    tests++; if (row_out2 !== 3'b010 || col_out2 !== 4'h2) begin failed++;
      $display("FAIL oor_row1: row=%b col=%h required 010 2", row_out2, col_out2); end
    step(3);                                                          // k=6
    tests++; if (row_out2 !== 3'b100 || col_out2 !== 4'h4) begin failed++;
      $display("FAIL oor_row2: row=%b col=%h required 100 4", row_out2, col_out2); end
    step(3);                                                          // k=9
    tests++; if ({fs2, row_out2, col_out2} !== {1'b1, 3'b001, 4'h1}) begin failed++;
      $display("FAIL front_untouched: fs=%b row=%b col=%h required 1 001 1", fs2, row_out2, col_out2); end
  endtask

  task automatic test_async_reset();
    bit ok;
    wait_fs(0, ok);
    tests++; if (!ok) begin failed++; $display("FAIL ar_fs_timeout: got none required frame_start"); end
    step(1);                                                          // k=1
    tests++; if (row_out0 !== 8'hFE || col_out0 !== 16'hFFFF) begin failed++;
      $display("FAIL ar_drive: row=%h col=%h required fe ffff", row_out0, col_out0); end
    swap_req0 = 1'b1; step(1); swap_req0 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    tests++; if ({row_out0, col_out0, swap_pend0, fs0} !== {8'hFF, 16'hFFFF, 2'b00}) begin failed++;
      $display("FAIL ar_async: row=%h col=%h pend=%b fs=%b required ff ffff 0 0",
               row_out0, col_out0, swap_pend0, fs0); end
    step(2); rst_n = 1'b1;
    wait_fs(0, ok);
    step(19);
    tests++; if (row_out0 !== 8'hF7 || col_out0 !== 16'hFFFF) begin failed++;
      $display("FAIL ar_cleared: row=%h col=%h required f7 ffff", row_out0, col_out0); end
  endtask

  initial begin
    rst_n = 1'b0;
    scan_en0 = 1'b1; wr_en0 = 1'b0; wr_row0 = '0; wr_data0 = '0; swap_req0 = 1'b0;
    scan_en1 = 1'b1; wr_en1 = 1'b0; wr_row1 = '0; wr_data1 = '0; swap_req1 = 1'b0;
    scan_en2 = 1'b1; wr_en2 = 1'b0; wr_row2 = '0; wr_data2 = '0; swap_req2 = 1'b0;
    test_reset();
    test_swap_scan();
    test_swap_midframe();
    test_double_swap();
    test_pause();
    test_out_of_range();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
